spdif_sample_feeder: RTL and testbench

- Upstream neighbour of the S/P DIF serializer in the HDMI audio path.
- Accepts stereo PCM frames from the audio engine, buffers them in a small synchronous FIFO, and hands samples one at a time to the serializer over its valid/rdy handshake, strictly left then right.
- Tracks the 192-frame channel-status block index.
- Handles FIFO underrun and enable/disable without breaking L/R alignment.

---
 rtl/spdif_pkg.sv | 22 ++
 rtl/spdif_sample_feeder_fifo.sv | 54 +++++
 rtl/spdif_sample_feeder.sv | 110 +++++++++++
 tb/tb_spdif_sample_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// rtl/spdif_pkg.sv - shared types and constants for the S/P DIF sample feeder
package spdif_pkg;

    typedef logic [15:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_frame_t;

    localparam int FRAMES_PER_BLOCK = 192;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_L,
        BUSY_L,
        WAIT_R,
        ISSUE_R,
        BUSY_R
    } feeder_state_e;

endpackage

// File: rtl/spdif_sample_feeder_fifo.sv
// rtl/spdif_sample_feeder_fifo.sv - synchronous stereo-frame FIFO (stereo_fifo)
module stereo_fifo
    import spdif_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  stereo_frame_t wr_data,
    input  logic          pop,
    output stereo_frame_t rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    stereo_frame_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // a full FIFO refuses writes even when a pop frees a slot in the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/spdif_sample_feeder.sv
// rtl/spdif_sample_feeder.sv - buffers stereo PCM and feeds the S/P DIF serializer L then R
// Optional build macro: SPDIF_UNDERRUN_HOLD_EN (repeat last frame on underrun instead of zeros)
module spdif_sample_feeder
    import spdif_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int SAMPLE_W = 16,
    parameter int UCNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [SAMPLE_W-1:0]      in_left,
    input  logic [SAMPLE_W-1:0]      in_right,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [SAMPLE_W-1:0]      spdif_data,
    output logic                     spdif_valid,
    input  logic                     spdif_rdy,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     underrun,
    output logic [UCNT_W-1:0]        underrun_count,
    output logic [7:0]               frame_idx
);

    feeder_state_e state;
    stereo_frame_t wr_frame;
    stereo_frame_t head;
    stereo_frame_t held;
    logic          full;
    logic          empty;
    logic          pop;

    assign wr_frame = stereo_frame_t'({in_left, in_right});
    assign in_ready = !full;
    assign pop      = (state == IDLE) && en && spdif_rdy && !empty;

    stereo_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .wr_data (wr_frame),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fill)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            held           <= '0;
            spdif_valid    <= 1'b0;
            spdif_data     <= '0;
            underrun       <= 1'b0;
            underrun_count <= '0;
            frame_idx      <= '0;
        end else begin
            spdif_valid <= 1'b0;
            underrun    <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && spdif_rdy) begin
                        state       <= ISSUE_L;
                        spdif_valid <= 1'b1;
                        if (!empty) begin
                            held       <= head;
                            spdif_data <= head.left;
                        end else begin
                            underrun <= 1'b1;
                            if (underrun_count != '1) begin
                                underrun_count <= underrun_count + 1'b1;
                            end
`ifdef SPDIF_UNDERRUN_HOLD_EN
                            spdif_data <= held.left;
`else
                            held       <= '0;
                            spdif_data <= '0;
`endif
                        end
                    end
                end
                ISSUE_L: state <= BUSY_L;
                // rdy is still high right after the strobe; wait for it to fall first
                BUSY_L: begin
                    if (!spdif_rdy) begin
                        state <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (spdif_rdy) begin
                        state       <= ISSUE_R;
                        spdif_valid <= 1'b1;
                        spdif_data  <= held.right;
                        frame_idx   <= (frame_idx == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_idx + 8'd1;
                    end
                end
                ISSUE_R: state <= BUSY_R;
                BUSY_R: begin
                    if (!spdif_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spdif_sample_feeder.sv
// tb/tb_spdif_sample_feeder.sv - randomized self-checking bench with a queue-based reference model
module tb_spdif_sample_feeder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] spdif_data;
    logic        spdif_valid;
    logic        spdif_rdy;
    logic [4:0]  fill;
    logic        underrun;
    logic [15:0] underrun_count;
    logic [7:0]  frame_idx;

    always #5 clk = ~clk;

    spdif_sample_feeder #(.DEPTH(DEPTH), .SAMPLE_W(16), .UCNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .in_left        (in_left),
        .in_right       (in_right),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .spdif_data     (spdif_data),
        .spdif_valid    (spdif_valid),
        .spdif_rdy      (spdif_rdy),
        .fill           (fill),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .frame_idx      (frame_idx)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // serializer: rdy falls the cycle after a load and stays low for hold_cycles
    int   hold_cycles = 64;
    int   ser_cnt     = 0;
    logic seen_v;
    initial begin
        spdif_rdy = 1'b1;
        forever begin
            @(negedge clk);
            seen_v = spdif_valid;
            @(posedge clk);
            #1;
            if (seen_v) ser_cnt = hold_cycles;
            else if (ser_cnt > 0) ser_cnt--;
            spdif_rdy = (ser_cnt == 0);
        end
    end

    // reference model: frame queue, strobe timing from rdy/en history
    logic [31:0] mq[$];
    logic [15:0] slog[$];
    int          strobe_cnt   = 0;
    int          prev_size    = 0;
    logic        prev_in_valid = 1'b0;
    logic [31:0] prev_frame   = '0;
    logic        prev_rst     = 1'b0;
    logic        started      = 1'b0;
    logic        exp_next     = 1'b0;
    logic        ready_flag   = 1'b1;
    logic        next_right   = 1'b0;
    logic [31:0] m_held       = '0;
    logic [31:0] pair;
    logic [15:0] last_data    = '0;
    int          ucount       = 0;
    int          idx          = 0;
    logic        exp_v;
    logic        exp_u;

    always @(negedge clk) begin
        exp_v = 1'b0;
        exp_u = 1'b0;
        if (!started) begin
            started = 1'b1;
        end else if (!prev_rst) begin
            mq.delete();
            ready_flag = 1'b1;
            next_right = 1'b0;
            m_held     = '0;
            last_data  = '0;
            ucount     = 0;
            idx        = 0;
            chk("rst_valid", 32'(spdif_valid), 32'd0);
            chk("rst_data", 32'(spdif_data), 32'd0);
            chk("rst_underrun", 32'(underrun), 32'd0);
        end else begin
            exp_v = exp_next;
            chk("strobe_timing", 32'(spdif_valid), 32'(exp_v));
            if (spdif_valid) begin
                strobe_cnt++;
                slog.push_back(spdif_data);
            end
            if (exp_v) begin
                if (!next_right) begin
                    if (prev_size > 0) begin
                        pair = mq.pop_front();
                    end else begin
                        exp_u = 1'b1;
                        if (ucount < 65535) ucount++;
`ifdef SPDIF_UNDERRUN_HOLD_EN
                        pair = m_held;
`else
                        pair = '0;
`endif
                    end
                    m_held     = pair;
                    last_data  = pair[31:16];
                    next_right = 1'b1;
                end else begin
                    last_data  = m_held[15:0];
                    idx        = (idx + 1) % 192;
                    next_right = 1'b0;
                end
            end
            chk("data", 32'(spdif_data), 32'(last_data));
            chk("underrun", 32'(underrun), 32'(exp_u));
            if (prev_in_valid && prev_size != DEPTH) mq.push_back(prev_frame);
        end
        if (started) begin
            chk("fill", 32'(fill), 32'(mq.size()));
            chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
            chk("underrun_count", 32'(underrun_count), 32'(ucount));
            chk("frame_idx", 32'(frame_idx), 32'(idx));
        end
        if (!rst) begin
            exp_next = 1'b0;
        end else begin
            if (exp_v) ready_flag = 1'b0;
            exp_next = ready_flag && spdif_rdy && (next_right || en);
            if (!spdif_rdy && !exp_v) ready_flag = 1'b1;
        end
        prev_size     = mq.size();
        prev_in_valid = in_valid;
        prev_frame    = {in_left, in_right};
        prev_rst      = rst;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_strobes(input string nm, input int n, input int budget);
        int k = 0;
        while (strobe_cnt < n && k < budget) begin
            step(1);
            k++;
        end
        chk(nm, 32'(strobe_cnt >= n), 32'd1);
    endtask

    logic [15:0] t1_exp [6];
    logic [15:0] t2_exp [4];
    int          base;
    int          acc;

    initial begin
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
        t1_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
`ifdef SPDIF_UNDERRUN_HOLD_EN
        t2_exp = '{16'hABCD, 16'h1234, 16'hABCD, 16'h1234};
`else
        t2_exp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
        do_reset();
        chk("reset_fill", 32'(fill), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // three preloaded frames, slow serializer
        push_frame(16'h1111, 16'h2222);
        push_frame(16'h3333, 16'h4444);
        push_frame(16'h5555, 16'h6666);
        base = strobe_cnt;
        en = 1'b1;
        wait_strobes("t1_wait", base + 6, 2000);
        en = 1'b0;
        for (int i = 0; i < 6; i++) chk("t1_sample", 32'(slog[base+i]), 32'(t1_exp[i]));
        chk("t1_frame_idx", 32'(frame_idx), 32'd3);
        chk("t1_ucount", 32'(underrun_count), 32'd0);
        step(80);

        // starved FIFO: five underrun frames
        do_reset();
        base = strobe_cnt;
        en = 1'b1;
        wait_strobes("t2_wait9", base + 9, 2000);
        en = 1'b0;
        wait_strobes("t2_wait10", base + 10, 200);
        for (int i = 0; i < 10; i++) chk("t2_zero", 32'(slog[base+i]), 32'd0);
        chk("t2_ucount", 32'(underrun_count), 32'd5);
        step(80);

        // one real frame, then starve
        do_reset();
        push_frame(16'hABCD, 16'h1234);
        base = strobe_cnt;
        en = 1'b1;
        wait_strobes("t2b_wait5", base + 5, 2000);
        en = 1'b0;
        wait_strobes("t2b_wait6", base + 6, 200);
        chk("t2b_left", 32'(slog[base]), 32'hABCD);
        chk("t2b_right", 32'(slog[base+1]), 32'h1234);
        for (int i = 0; i < 4; i++) chk("t2b_repeat", 32'(slog[base+2+i]), 32'(t2_exp[i]));
        step(80);

        // overfill with en low
        do_reset();
        base = strobe_cnt;
        acc  = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_left  = 16'($urandom);
            in_right = 16'($urandom);
            in_valid = 1'b1;
            if (in_ready) acc++;
            step(1);
        end
        in_valid = 1'b0;
        step(2);
        chk("t3_accepted", 32'(acc), 32'd16);
        chk("t3_fill", 32'(fill), 32'd16);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        chk("t3_no_strobe", 32'(strobe_cnt), 32'(base));

        // en dropped right after the left strobe
        do_reset();
        base = strobe_cnt;
        en = 1'b1;
        wait_strobes("t4_left", base + 1, 200);
        en = 1'b0;
        wait_strobes("t4_right", base + 2, 300);
        step(200);
        chk("t4_parked", 32'(strobe_cnt), 32'(base + 2));
        chk("t4_ucount", 32'(underrun_count), 32'd1);

        // 193 frames through the channel-status block
        hold_cycles = 1;
        do_reset();
        base = strobe_cnt;
        en = 1'b1;
        wait_strobes("t5_192", base + 384, 5000);
        chk("t5_wrap", 32'(frame_idx), 32'd0);
        wait_strobes("t5_193", base + 386, 100);
        en = 1'b0;
        chk("t5_after", 32'(frame_idx), 32'd1);
        step(20);

        // reset while waiting for the right slot
        hold_cycles = 64;
        do_reset();
        push_frame(16'h7777, 16'h8888);
        base = strobe_cnt;
        en = 1'b1;
        wait_strobes("t6_left", base + 1, 200);
        step(10);
        rst = 1'b0;
        en  = 1'b0;
        step(1);
        rst = 1'b1;
        chk("t6_valid", 32'(spdif_valid), 32'd0);
        chk("t6_fill", 32'(fill), 32'd0);
        chk("t6_frame_idx", 32'(frame_idx), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        step(200);
        chk("t6_no_right", 32'(strobe_cnt), 32'(base + 1));

        // randomized traffic
        for (int c = 0; c < 6000; c++) begin
            if (c % 250 == 0) hold_cycles = $urandom_range(1, 6);
            in_left  = 16'($urandom);
            in_right = 16'($urandom);
            in_valid = ((c / 500) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 40) == 0) en = ~en;
            rst = ($urandom_range(0, 700) != 0);
            step(1);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        en = 1'b0;
        step(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
